// File: rtl/spi_readback_tx.sv
// ----------------------------------------------------------------------------
// spi_readback_tx
//   SPI responder transmit path (mode 0). Shifts a readback frame out on SDO to
//   the MCU SPI master:
//     HEADER(8) | word 0 .. word NUM_WORDS-1 (MSB first) | CHK(8)
//   CHK is the XOR of all data bytes; the header is not included.
//   SCK and CS are asynchronous and are oversampled in the clk_in domain.
//
// Ports
//   clk_in      system clock, must run at least 8x the SCK rate
//   rst_in      asynchronous active-low reset
//   sck         SPI clock from the master (CPOL=0, CPHA=0)
//   cs          SPI chip select, active low
//   snap_i      flat snapshot; word k = snap_i[k*WORD_W +: WORD_W]
//   sdo         serial data out, MSB first
//   sdo_oe      SDO drive enable, high only while synchronized cs is low
//   busy        high in every state except IDLE
//   frame_done  1-cycle pulse once the last checksum bit has been sampled
//   frame_abort 1-cycle pulse when cs rises before the frame completes
// ----------------------------------------------------------------------------
module spi_readback_tx #(
  parameter int         NUM_WORDS   = 15,
  parameter int         WORD_W      = 16,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sck,
  input  logic                          cs,
  input  logic [NUM_WORDS*WORD_W-1:0]   snap_i,
  output logic                          sdo,
  output logic                          sdo_oe,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_abort
);

  localparam int DATA_W     = NUM_WORDS * WORD_W;
  localparam int TOTAL_BITS = DATA_W + 16;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BITS - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(TOTAL_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      snap_q, snap_d;
  logic                   sdo_q, sdo_d;
  logic                   sdo_oe_q, sdo_oe_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [7:0]             chk;
  logic [DATA_W-1:0]      data_ord;
  logic [TOTAL_BITS-1:0]  frame_vec;
  logic [TOTAL_BITS-1:0]  frame_shift;
  logic                   next_bit;

  // The cs synchronizer resets to 0 rather than the idle-high level: if cs is
  // still low when reset is released, no spurious cs_fall is seen, so a new
  // frame needs a genuine falling edge. A rise seen in IDLE is harmless.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // Frame image built from the captured snapshot. Word 0 sits directly under
  // the header so that shifting left by bit_cnt leaves the next bit in the MSB.
  always_comb begin
    chk      = 8'h00;
    data_ord = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      chk = chk ^ snap_q[b*8 +: 8];
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      data_ord[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = snap_q[k*WORD_W +: WORD_W];
    end
    frame_vec   = {HEADER, data_ord, chk};
    frame_shift = frame_vec << bit_cnt_q;
    next_bit    = frame_shift[TOTAL_BITS-1];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      snap_q    <= '0;
      sdo_q     <= 1'b0;
      sdo_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      snap_q    <= snap_d;
      sdo_q     <= sdo_d;
      sdo_oe_q  <= sdo_oe_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    snap_d    = snap_q;
    sdo_d     = sdo_q;
    sdo_oe_d  = sdo_oe_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
        if (cs_fall) begin
          snap_d    = snap_i;
          sdo_d     = HEADER[7];
          sdo_oe_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // The final rising edge wins over a coincident cs rise: the master has
        // already sampled every bit, so the frame counts as complete.
        if (sck_rise && (bit_cnt_q == LAST_CNT)) begin
          bit_cnt_d = END_CNT;
          done_d    = 1'b1;
          sdo_d     = 1'b0;
          if (cs_rise) begin
            sdo_oe_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT_CS;
          end
        end else if (cs_rise) begin
          abort_d   = 1'b1;
          sdo_d     = 1'b0;
          sdo_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (sck_fall) begin
          sdo_d = next_bit;
        end
      end

      WAIT_CS: begin
        sdo_d = 1'b0;
        if (cs_rise) begin
          sdo_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign sdo         = sdo_q;
  assign sdo_oe      = sdo_oe_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_readback_tx.sv
// ----------------------------------------------------------------------------
// tb_spi_readback_tx
//   Self-checking bench for spi_readback_tx. Expected MISO bytes are queued
//   when a frame is issued; a monitor assembles bytes sampled on SCK rising
//   edges and compares them against the queue. Pulse counters track
//   frame_done / frame_abort and are checked after each scenario.
// ----------------------------------------------------------------------------
module tb_spi_readback_tx;

  localparam int NW = 15;
  localparam int WW = 16;
  localparam int SCK_HALF = 200;

  logic               clk_in;
  logic               rst_in;
  logic               sck;
  logic               cs;
  logic [NW*WW-1:0]   snap_i;
  logic               sdo;
  logic               sdo_oe;
  logic               busy;
  logic               frame_done;
  logic               frame_abort;

  logic [7:0]         expQ[$];
  int                 total;
  int                 bad;
  int                 doneCount;
  int                 abortCount;
  int                 rxBits;
  int                 rxIndex;
  logic [7:0]         rxByte;
  logic               toggleOn;

  logic [NW*WW-1:0]   pat1;
  logic [NW*WW-1:0]   pat2;
  logic [NW*WW-1:0]   pat4;

  spi_readback_tx dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sck         (sck),
    .cs          (cs),
    .snap_i      (snap_i),
    .sdo         (sdo),
    .sdo_oe      (sdo_oe),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  initial clk_in = 1'b0;
  always #20 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queue the first nBytes of the expected MISO stream for a snapshot; bytes
  // beyond the checksum are the zeros driven while waiting for cs to rise.
  task automatic pushFrame(input logic [NW*WW-1:0] snap, input int nBytes,
                           input logic [7:0] chk);
    logic [7:0]  b;
    logic [15:0] w;
    int          k;
    for (int i = 0; i < nBytes; i++) begin
      if (i == 0) begin
        b = 8'hA5;
      end else if (i <= 2*NW) begin
        k = (i - 1) / 2;
        w = snap[k*WW +: WW];
        b = (i % 2 == 1) ? w[15:8] : w[7:0];
      end else if (i == 2*NW + 1) begin
        b = chk;
      end else begin
        b = 8'h00;
      end
      expQ.push_back(b);
    end
  endtask

  // Lower cs, give the responder time to load, then run nClocks SCK periods.
  // cs is raised afterwards only when raiseCs is set.
  task automatic applyStimulus(input int nClocks, input bit raiseCs);
    cs = 1'b0;
    repeat (8) @(negedge clk_in);
    for (int i = 0; i < nClocks; i++) begin
      #SCK_HALF sck = 1'b1;
      #SCK_HALF sck = 1'b0;
    end
    repeat (3) @(negedge clk_in);
    if (raiseCs) begin
      cs = 1'b1;
      repeat (10) @(negedge clk_in);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    doneCount  = 0;
    abortCount = 0;
    rxBits     = 0;
    rxIndex    = 0;
    rxByte     = 8'h00;
    toggleOn   = 1'b0;
    rst_in     = 1'b0;
    sck        = 1'b0;
    cs         = 1'b1;
    snap_i     = '0;

    pat1 = '0;
    pat2 = '0;
    pat4 = '0;
    for (int k = 0; k < NW; k++) begin
      pat1[k*WW +: WW] = 16'(k * 257);
      pat4[k*WW +: WW] = 16'hC3A5;
    end
    pat2[15:0] = 16'h4000;
    pat4[15:0] = 16'h1200;

    fork
      // Monitor: assemble MISO bytes and score them against the queue.
      forever begin
        @(posedge sck or posedge cs);
        if (cs) begin
          rxBits = 0;
        end else begin
          rxByte = {rxByte[6:0], sdo};
          rxBits++;
          if (rxBits == 8) begin
            rxBits = 0;
            total++;
            if (expQ.size() == 0) begin
              bad++;
              $display("[TB] FAIL byte%0d: got %02h expected none", rxIndex, rxByte);
            end else begin
              logic [7:0] exp;
              exp = expQ.pop_front();
              if (rxByte !== exp) begin
                bad++;
                $display("[TB] FAIL byte%0d: got %02h expected %02h", rxIndex, rxByte, exp);
              end
            end
            rxIndex++;
          end
        end
      end

      forever begin
        @(negedge clk_in);
        if (frame_done === 1'b1) doneCount++;
        if (frame_abort === 1'b1) abortCount++;
      end

      begin
        repeat (4) @(negedge clk_in);
        checkOutput("reset_sdo", 32'(sdo), 32'd0);
        checkOutput("reset_sdo_oe", 32'(sdo_oe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(frame_done), 32'd0);
        checkOutput("reset_abort", 32'(frame_abort), 32'd0);
        rst_in = 1'b1;
        repeat (6) @(negedge clk_in);

        // Ramp pattern, pairs cancel in the checksum.
        $display("[TB] test 1: ramp frame");
        snap_i = pat1;
        pushFrame(pat1, 32, 8'h00);
        applyStimulus(256, 1'b1);
        checkOutput("t1_done", 32'(doneCount), 32'd1);
        checkOutput("t1_abort", 32'(abortCount), 32'd0);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        $display("[TB] test 2: single 0.5 coefficient");
        snap_i = pat2;
        pushFrame(pat2, 32, 8'h40);
        applyStimulus(256, 1'b1);
        checkOutput("t2_done", 32'(doneCount), 32'd2);

        $display("[TB] test 3: abort after 100 clocks");
        snap_i = pat1;
        pushFrame(pat1, 12, 8'h00);
        applyStimulus(100, 1'b0);
        checkOutput("t3_oe_before", 32'(sdo_oe), 32'd1);
        cs = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        checkOutput("t3_oe_off", 32'(sdo_oe), 32'd0);
        repeat (8) @(negedge clk_in);
        checkOutput("t3_abort", 32'(abortCount), 32'd1);
        checkOutput("t3_no_done", 32'(doneCount), 32'd2);
        pushFrame(pat1, 32, 8'h00);
        applyStimulus(256, 1'b1);
        checkOutput("t3_restart_done", 32'(doneCount), 32'd3);

        $display("[TB] test 4: snapshot toggling mid-frame");
        snap_i   = pat4;
        toggleOn = 1'b1;
        pushFrame(pat4, 32, 8'h12);
        fork
          begin
            applyStimulus(256, 1'b1);
            toggleOn = 1'b0;
          end
          begin
            repeat (6) @(negedge clk_in);
            while (toggleOn) begin
              @(negedge clk_in);
              snap_i = ~snap_i;
            end
          end
        join
        checkOutput("t4_done", 32'(doneCount), 32'd4);

        $display("[TB] test 5: reset at bit 50");
        snap_i = pat1;
        pushFrame(pat1, 6, 8'h00);
        applyStimulus(50, 1'b0);
        checkOutput("t5_busy_before", 32'(busy), 32'd1);
        rst_in = 1'b0;
        #1;
        checkOutput("t5_rst_sdo", 32'(sdo), 32'd0);
        checkOutput("t5_rst_oe", 32'(sdo_oe), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        cs = 1'b1;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (6) @(negedge clk_in);
        checkOutput("t5_idle_after", 32'(busy), 32'd0);
        snap_i = pat2;
        pushFrame(pat2, 32, 8'h40);
        applyStimulus(256, 1'b1);
        checkOutput("t5_done", 32'(doneCount), 32'd5);

        $display("[TB] test 6: 300 clocks in one window");
        snap_i = pat2;
        pushFrame(pat2, 37, 8'h40);
        applyStimulus(300, 1'b1);
        checkOutput("t6_done", 32'(doneCount), 32'd6);
        checkOutput("t6_abort", 32'(abortCount), 32'd1);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
